chip_test_ctrl: RTL and testbench

Run-handshake controller placed directly upstream of a chip checker (e.g. the 74157N checker). It turns a raw start button into a Run request and waits for the checker's Done, with a watchdog timeout. It latches RSLT into sticky pass/fail/timeout flags and keeps saturating pass/fail tallies for the LED/hex display logic.

---
 rtl/chip_test_ctrl_if.sv | 28 ++
 rtl/chip_test_ctrl.sv | 131 +++++++++++++
 tb/tb_chip_test_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/chip_test_ctrl_if.sv
// Signal bundle between the run-handshake controller, the start button and the chip checker.
// The master side is the controller; the slave side is the checker/button/display environment.
interface chip_test_ctrl_if #(
    parameter int unsigned CNT_W = 8
);
    logic             Start_btn;
    logic             Clear_cnt;
    logic             Run;
    logic             Done;
    logic             RSLT;
    logic             Busy;
    logic             Result_valid;
    logic             Pass;
    logic             Fail;
    logic             Timeout;
    logic [CNT_W-1:0] Pass_count;
    logic [CNT_W-1:0] Fail_count;

    modport master (
        input  Start_btn, Clear_cnt, Done, RSLT,
        output Run, Busy, Result_valid, Pass, Fail, Timeout, Pass_count, Fail_count
    );

    modport slave (
        output Start_btn, Clear_cnt, Done, RSLT,
        input  Run, Busy, Result_valid, Pass, Fail, Timeout, Pass_count, Fail_count
    );
endinterface

// File: rtl/chip_test_ctrl.sv
// Run-handshake controller for a chip checker: synchronised start, Run/Done handshake with
// watchdog, sticky verdict flags and saturating pass/fail tallies.
module chip_test_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input logic              Clk,
    input logic              Reset,
    chip_test_ctrl_if.master bus
);
    localparam int unsigned      WD_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {StIdle, StRun, StWaitLow} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_prev_q;
    logic                   start_evt;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic                   run_q, run_d;
    logic                   pass_q, pass_d;
    logic                   fail_q, fail_d;
    logic                   tmo_q, tmo_d;
    logic                   pass_inc, fail_inc;
    logic [CNT_W-1:0]       pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]       fail_cnt_q, fail_cnt_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_q     <= '0;
            btn_prev_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.Start_btn};
            btn_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // One event per press, however long the button is held.
    assign start_evt = sync_q[SYNC_STAGES-1] & ~btn_prev_q;

    always_comb begin
        state_d  = state_q;
        wd_d     = wd_q;
        run_d    = run_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        tmo_d    = tmo_q;
        pass_inc = 1'b0;
        fail_inc = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_evt) begin
                    state_d = StRun;
                    run_d   = 1'b1;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    tmo_d   = 1'b0;
                    wd_d    = '0;
                end
            end
            StRun: begin
                // Done wins over a watchdog expiry in the same cycle.
                if (bus.Done) begin
                    pass_d   = bus.RSLT;
                    fail_d   = ~bus.RSLT;
                    pass_inc = bus.RSLT;
                    fail_inc = ~bus.RSLT;
                    run_d    = 1'b0;
                    state_d  = StWaitLow;
                end else if (wd_q == WD_LAST) begin
                    tmo_d    = 1'b1;
                    fail_inc = 1'b1;
                    run_d    = 1'b0;
                    state_d  = StWaitLow;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            StWaitLow: begin
                if (!bus.Done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        if (bus.Clear_cnt) begin
            pass_cnt_d = '0;
            fail_cnt_d = '0;
        end else begin
            if (pass_inc && pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + 1'b1;
            if (fail_inc && fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= StIdle;
            wd_q       <= '0;
            run_q      <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            tmo_q      <= 1'b0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wd_q       <= wd_d;
            run_q      <= run_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            tmo_q      <= tmo_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign bus.Run          = run_q;
    assign bus.Busy         = (state_q != StIdle);
    assign bus.Result_valid = pass_q | fail_q | tmo_q;
    assign bus.Pass         = pass_q;
    assign bus.Fail         = fail_q;
    assign bus.Timeout      = tmo_q;
    assign bus.Pass_count   = pass_cnt_q;
    assign bus.Fail_count   = fail_cnt_q;
endmodule

// File: tb/tb_chip_test_ctrl.sv
// Bench for chip_test_ctrl: directed and random runs against a behavioural model of the
// start/Run/Done handshake, checked every cycle, plus literal expectations for key scenarios.
module tb_chip_test_ctrl;
    localparam int T    = 16;
    localparam int CW   = 2;
    localparam int S    = 2;
    localparam int CMAX = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    chip_test_ctrl_if #(.CNT_W(CW)) bus ();

    chip_test_ctrl #(
        .TIMEOUT_CYCLES(T),
        .CNT_W         (CW),
        .SYNC_STAGES   (S)
    ) dut (
        .Clk  (clk),
        .Reset(rst),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: button history, test in progress, waiting for Done release, verdict.
    bit hist [0:S];
    bit m_run, m_wait, m_pass, m_fail, m_tmo;
    int m_age, m_pcnt, m_fcnt, m_extra_left;

    // Checker model settings: Run length in cycles (0 = never answers), verdict, extra hold.
    int chk_len   = 0;
    int chk_extra = 0;
    bit chk_rslt  = 1'b0;
    bit force_done = 1'b0;

    int dut_run_len  = 0;
    bit dut_run_prev = 1'b0;

    task automatic chk(string name, logic [31:0] act, int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit done_now();
        return force_done || (m_run && chk_len > 0 && m_age >= chk_len - 1) ||
               (m_wait && m_extra_left > 0);
    endfunction

    task automatic model_edge(bit btn, bit clr, bit done, bit rslt, bit reset);
        bit evt;
        int pi = 0;
        int fi = 0;
        if (reset) begin
            for (int i = 0; i <= S; i++) hist[i] = 1'b0;
            m_run = 0; m_wait = 0; m_pass = 0; m_fail = 0; m_tmo = 0;
            m_age = 0; m_pcnt = 0; m_fcnt = 0; m_extra_left = 0;
            return;
        end
        evt = hist[S-1] && !hist[S];
        for (int i = S; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = btn;
        if (m_run) begin
            if (done) begin
                m_pass = rslt; m_fail = !rslt;
                if (rslt) pi = 1; else fi = 1;
                m_run = 0; m_wait = 1; m_extra_left = chk_extra;
            end else if (m_age == T - 1) begin
                m_tmo = 1; fi = 1;
                m_run = 0; m_wait = 1; m_extra_left = 0;
            end else begin
                m_age++;
            end
        end else if (m_wait) begin
            if (!done) m_wait = 0;
            else if (m_extra_left > 0) m_extra_left--;
        end else if (evt) begin
            m_run = 1; m_pass = 0; m_fail = 0; m_tmo = 0; m_age = 0;
        end
        m_pcnt = clr ? 0 : ((m_pcnt + pi > CMAX) ? CMAX : m_pcnt + pi);
        m_fcnt = clr ? 0 : ((m_fcnt + fi > CMAX) ? CMAX : m_fcnt + fi);
    endtask

    task automatic check_all();
        if (bus.Run === 1'b1) dut_run_len = dut_run_prev ? dut_run_len + 1 : 1;
        dut_run_prev = (bus.Run === 1'b1);
        chk("run", bus.Run, int'(m_run));
        chk("busy", bus.Busy, int'(m_run | m_wait));
        chk("result_valid", bus.Result_valid, int'(m_pass | m_fail | m_tmo));
        chk("pass", bus.Pass, int'(m_pass));
        chk("fail", bus.Fail, int'(m_fail));
        chk("timeout", bus.Timeout, int'(m_tmo));
        chk("pass_count", bus.Pass_count, m_pcnt);
        chk("fail_count", bus.Fail_count, m_fcnt);
    endtask

    // Inputs change on the falling edge; the model steps on the rising edge.
    task automatic tick(bit btn, bit clr, bit reset);
        bit d;
        bit r;
        d = done_now();
        r = d ? chk_rslt : 1'($urandom_range(1));
        bus.Start_btn = btn;
        bus.Clear_cnt = clr;
        bus.Done      = d;
        bus.RSLT      = r;
        rst           = reset;
        @(posedge clk);
        model_edge(btn, clr, d, r, reset);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_test(int len, bit r, int extra, int hold, int repress, bit clr_verdict,
                           bit rnd_clr);
        bit started = 1'b0;
        bit fin = 1'b0;
        chk_len = len; chk_rslt = r; chk_extra = extra;
        for (int c = 0; c < 400; c++) begin
            bit b;
            bit cl;
            b  = (c < hold) || (repress > 0 && c >= repress && c < repress + 2);
            cl = rnd_clr ? ($urandom_range(15) == 0) : 1'b0;
            if (clr_verdict && m_run && done_now()) cl = 1'b1;
            tick(b, cl, 1'b0);
            if (m_run || m_wait) started = 1'b1;
            if (started && !m_run && !m_wait && bus.Busy === 1'b0 && c >= hold &&
                c >= repress + 2) begin
                fin = 1'b1;
                break;
            end
        end
        chk("test_completes", fin, 1);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.Start_btn = 1'b0; bus.Clear_cnt = 1'b0; bus.Done = 1'b0; bus.RSLT = 1'b0;
        @(negedge clk);
        repeat (3) tick(1'b0, 1'b0, 1'b1);
        chk("lit_reset_run", bus.Run, 0);
        chk("lit_reset_busy", bus.Busy, 0);
        chk("lit_reset_valid", bus.Result_valid, 0);
        chk("lit_reset_pcnt", bus.Pass_count, 0);

        // Pass: Run high 5 cycles
        do_test(5, 1'b1, 0, 3, 0, 1'b0, 1'b0);
        chk("lit_pass_run_len", dut_run_len, 5);
        chk("lit_pass_flag", bus.Pass, 1);
        chk("lit_pass_fail_flag", bus.Fail, 0);
        chk("lit_pass_pcnt", bus.Pass_count, 1);

        // Fail then pass
        tick(1'b0, 1'b1, 1'b0);
        do_test(4, 1'b0, 1, 2, 0, 1'b0, 1'b0);
        chk("lit_fail_flag", bus.Fail, 1);
        chk("lit_fail_fcnt", bus.Fail_count, 1);
        do_test(3, 1'b1, 2, 2, 0, 1'b0, 1'b0);
        chk("lit_fp_pass", bus.Pass, 1);
        chk("lit_fp_fail", bus.Fail, 0);
        chk("lit_fp_pcnt", bus.Pass_count, 1);
        chk("lit_fp_fcnt", bus.Fail_count, 1);

        // Timeout, then Done arriving on the last watchdog cycle
        tick(1'b0, 1'b1, 1'b0);
        do_test(0, 1'b1, 0, 2, 0, 1'b0, 1'b0);
        chk("lit_tmo_run_len", dut_run_len, 16);
        chk("lit_tmo_flag", bus.Timeout, 1);
        chk("lit_tmo_fcnt", bus.Fail_count, 1);
        chk("lit_tmo_busy", bus.Busy, 0);
        do_test(16, 1'b1, 0, 2, 0, 1'b0, 1'b0);
        chk("lit_edge_run_len", dut_run_len, 16);
        chk("lit_edge_tmo", bus.Timeout, 0);
        chk("lit_edge_pass", bus.Pass, 1);

        // Held button plus a second press during RUN
        tick(1'b0, 1'b1, 1'b0);
        do_test(10, 1'b1, 0, 50, 0, 1'b0, 1'b0);
        do_test(12, 1'b1, 0, 2, 7, 1'b0, 1'b0);
        chk("lit_filter_pcnt", bus.Pass_count, 2);

        // Saturation and clear on the verdict edge
        tick(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) do_test(1, 1'b1, 0, 1, 0, 1'b0, 1'b0);
        chk("lit_sat_pcnt", bus.Pass_count, 3);
        do_test(3, 1'b1, 0, 1, 0, 1'b1, 1'b0);
        chk("lit_clr_pcnt", bus.Pass_count, 0);
        chk("lit_clr_pass_flag", bus.Pass, 1);

        // Reset mid-test, then a stray Done
        do_test(3, 1'b1, 0, 2, 0, 1'b0, 1'b0);
        chk_len = 0;
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 10 && !m_run; c++) tick(1'b0, 1'b0, 1'b0);
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        chk("lit_rst_run", bus.Run, 0);
        chk("lit_rst_valid", bus.Result_valid, 0);
        chk("lit_rst_pcnt", bus.Pass_count, 0);
        chk_rslt = 1'b1;
        force_done = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        force_done = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
        chk("lit_stray_pcnt", bus.Pass_count, 0);
        chk("lit_stray_busy", bus.Busy, 0);

        // Random runs
        for (int i = 0; i < 40; i++) begin
            do_test(int'($urandom_range(20)), 1'($urandom_range(1)),
                    int'($urandom_range(3)), int'($urandom_range(6, 1)), 0, 1'b0, 1'b1);
            repeat ($urandom_range(3)) tick(1'b0, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
